// File: rtl/stopwatch_control.sv
// Stopwatch front-end: synchronizes and debounces two buttons, runs the ZERO/RUN/LAP/STOP FSM,
// and drives run enable, clear pulse, lap snapshot and display mux toward the counter chain.
module stopwatch_control #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_stop_btn_i,
    input  logic        lap_reset_btn_i,
    input  logic [31:0] live_i,
    output logic        count_en_o,
    output logic        clear_o,
    output logic [31:0] display_o,
    output logic [3:0]  lap_count_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ZERO = 2'b00,
        RUN  = 2'b01,
        LAP  = 2'b10,
        STOP = 2'b11
    } state_t;

    localparam logic [15:0] DB_MAX = 16'(DEBOUNCE_CYCLES);

    // Index 0 is start/stop, index 1 is lap/reset.
    logic [1:0]  btn_raw;
    logic [1:0]  sync1_q, sync2_q;
    logic [1:0]  deb_q, deb_d;
    logic [1:0]  arm_q, arm_d;
    logic [1:0]  press_q, press_d;
    logic [1:0]  fill_q, fill_d;
    logic [15:0] cnt_q [2];
    logic [15:0] cnt_d [2];

    state_t      state_q, state_d;
    logic        count_en_q, count_en_d;
    logic        clear_q, clear_d;
    logic [31:0] lap_q, lap_d;
    logic [3:0]  lap_cnt_q, lap_cnt_d;

    logic        ss_ev, lr_ev;

    assign btn_raw = {lap_reset_btn_i, start_stop_btn_i};
    assign ss_ev   = press_q[0];
    assign lr_ev   = press_q[1];

    // A button only arms once its synchronized level has been seen low after reset,
    // so a button held through reset release never produces a press.
    always_comb begin
        fill_d = {fill_q[0], 1'b1};
        for (int b = 0; b < 2; b++) begin
            deb_d[b] = deb_q[b];
            cnt_d[b] = '0;
            if (sync2_q[b] != deb_q[b]) begin
                if (cnt_q[b] == DB_MAX) begin
                    deb_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 16'd1;
                end
            end
            arm_d[b]   = arm_q[b] | (fill_q[1] & ~sync2_q[b]);
            press_d[b] = arm_q[b] & deb_d[b] & ~deb_q[b];
        end
    end

    always_comb begin
        state_d   = state_q;
        clear_d   = 1'b0;
        lap_d     = lap_q;
        lap_cnt_d = lap_cnt_q;
        unique case (state_q)
            ZERO: begin
                if (ss_ev) state_d = RUN;
            end
            RUN: begin
                if (ss_ev) begin
                    state_d = STOP;
                end else if (lr_ev) begin
                    state_d = LAP;
                    lap_d   = live_i;
                    if (lap_cnt_q != 4'd15) lap_cnt_d = lap_cnt_q + 4'd1;
                end
            end
            LAP: begin
                if (ss_ev) begin
                    state_d = STOP;
                end else if (lr_ev) begin
                    state_d = RUN;
                end
            end
            STOP: begin
                if (ss_ev) begin
                    state_d = RUN;
                end else if (lr_ev) begin
                    state_d   = ZERO;
                    clear_d   = 1'b1;
                    lap_cnt_d = '0;
                end
            end
            default: state_d = ZERO;
        endcase
        count_en_d = (state_d == RUN) || (state_d == LAP);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            arm_q      <= '0;
            press_q    <= '0;
            fill_q     <= '0;
            for (int b = 0; b < 2; b++) cnt_q[b] <= '0;
            state_q    <= ZERO;
            count_en_q <= 1'b0;
            clear_q    <= 1'b0;
            lap_q      <= '0;
            lap_cnt_q  <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            arm_q      <= arm_d;
            press_q    <= press_d;
            fill_q     <= fill_d;
            for (int b = 0; b < 2; b++) cnt_q[b] <= cnt_d[b];
            state_q    <= state_d;
            count_en_q <= count_en_d;
            clear_q    <= clear_d;
            lap_q      <= lap_d;
            lap_cnt_q  <= lap_cnt_d;
        end
    end

    assign state_o     = state_q;
    assign count_en_o  = count_en_q;
    assign clear_o     = clear_q;
    assign lap_count_o = lap_cnt_q;
    assign display_o   = (state_q == LAP) ? lap_q : live_i;

endmodule

// File: tb/tb_stopwatch_control.sv
// Randomized bench for stopwatch_control against a cycle-level behavioural model of the buttons and FSM.
module tb_stopwatch_control;

    localparam int D = 4;
    localparam int S_ZERO = 0, S_RUN = 1, S_LAP = 2, S_STOP = 3;

    logic        clk = 1'b0;
    logic        rst, ss, lr;
    logic [31:0] live;
    logic        count_en, clear;
    logic [31:0] display;
    logic [3:0]  lap_count;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          m_st;
    bit          m_clr;
    logic [31:0] m_lap;
    int          m_laps;
    bit          lvl   [2];
    bit          armed [2];
    int          due   [2];
    int          nsamp [2];
    logic [D:0]  win   [2];

    stopwatch_control #(.DEBOUNCE_CYCLES(D)) dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .start_stop_btn_i(ss),
        .lap_reset_btn_i (lr),
        .live_i          (live),
        .count_en_o      (count_en),
        .clear_o         (clear),
        .display_o       (display),
        .lap_count_o     (lap_count),
        .state_o         (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = S_ZERO; m_clr = 0; m_lap = '0; m_laps = 0;
        for (int b = 0; b < 2; b++) begin
            lvl[b] = 0; armed[b] = 0; due[b] = 0; nsamp[b] = 0; win[b] = '0;
        end
    endfunction

    // A level is accepted once D+1 consecutive samples disagree with it; an accepted
    // rising level on an armed button reaches the FSM three edges after its last sample.
    function automatic void model_edge();
        bit ev [2];
        bit raw [2];
        if (rst) begin
            model_reset();
            return;
        end
        raw[0] = ss; raw[1] = lr;
        for (int b = 0; b < 2; b++) begin
            ev[b] = 0;
            if (due[b] > 0) begin
                due[b]--;
                if (due[b] == 0) ev[b] = 1;
            end
        end
        m_clr = 0;
        case (m_st)
            S_ZERO: if (ev[0]) m_st = S_RUN;
            S_RUN: begin
                if (ev[0]) m_st = S_STOP;
                else if (ev[1]) begin
                    m_st = S_LAP; m_lap = live;
                    m_laps = (m_laps < 15) ? m_laps + 1 : 15;
                end
            end
            S_LAP: begin
                if (ev[0]) m_st = S_STOP;
                else if (ev[1]) m_st = S_RUN;
            end
            default: begin
                if (ev[0]) m_st = S_RUN;
                else if (ev[1]) begin m_st = S_ZERO; m_clr = 1; m_laps = 0; end
            end
        endcase
        for (int b = 0; b < 2; b++) begin
            if (!raw[b]) armed[b] = 1;
            win[b] = {win[b][D-1:0], raw[b]};
            nsamp[b]++;
            if (nsamp[b] >= D + 1 && raw[b] != lvl[b] &&
                win[b] == (raw[b] ? {(D+1){1'b1}} : {(D+1){1'b0}})) begin
                lvl[b] = raw[b];
                if (raw[b] && armed[b]) due[b] = 3;
            end
        end
    endfunction

    // Called at a falling edge: check outputs, drive next inputs, advance one rising edge.
    task automatic cycle(input bit r, input bit s, input bit l);
        chk("state", 32'(state), 32'(m_st));
        chk("count_en", 32'(count_en), 32'((m_st == S_RUN) || (m_st == S_LAP)));
        chk("clear", 32'(clear), 32'(m_clr));
        chk("display", display, (m_st == S_LAP) ? m_lap : live);
        chk("lap_count", 32'(lap_count), 32'(m_laps));
        rst = r; ss = s; lr = l;
        live = (($urandom % 8) == 0) ? 32'h00012345 : $urandom;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic hold(input bit s, input bit l, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, s, l);
    endtask

    initial begin
        int rem_s, rem_l;
        bit vs, vl;
        rst = 1'b1; ss = 1'b0; lr = 1'b0; live = '0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);

        // start from ZERO, lap in and out, stop and reset to ZERO
        hold(0, 0, 3);
        hold(1, 0, 20); hold(0, 0, 10);
        hold(0, 1, 8);  hold(0, 0, 12);
        hold(0, 1, 8);  hold(0, 0, 12);
        hold(1, 0, 8);  hold(0, 0, 10);
        hold(0, 1, 8);  hold(0, 0, 10);

        // short glitch, then bounce before a stable press
        hold(1, 0, 3);  hold(0, 0, 8);
        hold(1, 0, 2);  hold(0, 0, 2); hold(1, 0, 2); hold(0, 0, 2);
        hold(1, 0, 12); hold(0, 0, 10);

        // simultaneous presses from RUN, then back to RUN
        hold(1, 1, 8);  hold(0, 0, 10);
        hold(1, 0, 8);  hold(0, 0, 10);

        // lap counter saturation
        for (int i = 0; i < 34; i++) begin
            hold(0, 1, 7); hold(0, 0, 7);
        end

        // reset while in LAP with start/stop held through release
        hold(0, 1, 7); hold(0, 0, 7);
        hold(1, 0, 2); cycle(1'b1, 1'b1, 1'b0);
        hold(1, 0, 16); hold(0, 0, 8);
        hold(1, 0, 8);  hold(0, 0, 10);

        // random button activity with occasional resets
        rem_s = 0; rem_l = 0; vs = 0; vl = 0;
        for (int i = 0; i < 4000; i++) begin
            if (rem_s == 0) begin vs = $urandom_range(0, 1); rem_s = $urandom_range(1, 14); end
            if (rem_l == 0) begin vl = $urandom_range(0, 1); rem_l = $urandom_range(1, 14); end
            rem_s--; rem_l--;
            cycle(($urandom % 500) == 0, vs, vl);
        end
        hold(0, 0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
